// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use/branch interlocks and data-memory wait/timeout FSM.
// Optional HAZARD_STATS_EN adds a saturating 16-bit stall_count output.
module hazard_unit #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       mem_to_reg_e,
  input  logic       mem_to_reg_m,
  input  logic       branch_d,
  input  logic       mem_req_m,
  input  logic       mem_ready_m,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       forward_a_d,
  output logic       forward_b_d,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_e,
  output logic       flush_w,
  output logic       mem_error
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_count
`endif
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_stall;
  logic             lw_stall;
  logic             branch_stall;

  // Operand forwarding; M wins over W, register 0 never forwards.
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == rs_e))
      forward_a_e = 2'b10;
    else if (reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == rs_e))
      forward_a_e = 2'b01;
    if (reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == rt_e))
      forward_b_e = 2'b10;
    else if (reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == rt_e))
      forward_b_e = 2'b01;
    forward_a_d = reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == rs_d);
    forward_b_d = reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == rt_d);
  end

  always_comb begin
    lw_stall     = mem_to_reg_e && ((rt_e == rs_d) || (rt_e == rt_d));
    branch_stall = branch_d &&
      ((reg_write_e && (write_reg_e != 5'd0) &&
        ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
       (mem_to_reg_m && (write_reg_m != 5'd0) &&
        ((write_reg_m == rs_d) || (write_reg_m == rt_d))));
  end

  // Memory stall is forced low while reset is held.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      RUN:      mem_stall = mem_req_m && !mem_ready_m;
      MEM_WAIT: mem_stall = !mem_ready_m;
      ERROR:    mem_stall = 1'b1;
      default:  mem_stall = 1'b0;
    endcase
    if (!rst_n) mem_stall = 1'b0;
  end

  always_comb begin
    stall_f = lw_stall || branch_stall || mem_stall;
    stall_d = stall_f;
    stall_e = mem_stall;
    stall_m = mem_stall;
    flush_w = mem_stall;
    flush_e = (lw_stall || branch_stall) && !mem_stall;
  end

  // Wait/timeout FSM; ERROR is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req_m && !mem_ready_m) begin
            state    <= MEM_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready_m) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            state     <= ERROR;
            mem_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ERROR:   mem_error <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall_f && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic       mem_to_reg_e, mem_to_reg_m, branch_d, mem_req_m, mem_ready_m;

  logic [1:0] fae0, fbe0, fae1, fbe1;
  logic       fad0, fbd0, sf0, sd0, se0, sm0, fe0, fw0, me0;
  logic       fad1, fbd1, sf1, sd1, se1, sm1, fe1, fw1, me1;
`ifdef HAZARD_STATS_EN
  logic [15:0] sc0, sc1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural memory model per instance: stall cycles in current episode and sticky error.
  int unsigned tmo [2] = '{16, 4};
  int unsigned mlen[2];
  bit          merr[2];

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m), .branch_d(branch_d),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .forward_a_e(fae0), .forward_b_e(fbe0), .forward_a_d(fad0), .forward_b_d(fbd0),
    .stall_f(sf0), .stall_d(sd0), .stall_e(se0), .stall_m(sm0),
    .flush_e(fe0), .flush_w(fw0), .mem_error(me0)
`ifdef HAZARD_STATS_EN
    , .stall_count(sc0)
`endif
  );

  hazard_unit #(.MEM_TIMEOUT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m), .branch_d(branch_d),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .forward_a_e(fae1), .forward_b_e(fbe1), .forward_a_d(fad1), .forward_b_d(fbd1),
    .stall_f(sf1), .stall_d(sd1), .stall_e(se1), .stall_m(sm1),
    .flush_e(fe1), .flush_w(fw1), .mem_error(me1)
`ifdef HAZARD_STATS_EN
    , .stall_count(sc1)
`endif
  );

  wire [12:0] obs0 = {fae0, fbe0, fad0, fbd0, sf0, sd0, se0, sm0, fe0, fw0, me0};
  wire [12:0] obs1 = {fae1, fbe1, fad1, fbd1, sf1, sd1, se1, sm1, fe1, fw1, me1};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_e(input logic [4:0] src);
    if (reg_write_m && write_reg_m != 0 && write_reg_m == src) return 2'b10;
    if (reg_write_w && write_reg_w != 0 && write_reg_w == src) return 2'b01;
    return 2'b00;
  endfunction

  // Expected output vector from current inputs plus the model's mem stall/error.
  function automatic logic [12:0] expect_out(input logic ms, input logic me);
    logic lw, br, hz, fad, fbd;
    fad = reg_write_m && write_reg_m != 0 && write_reg_m == rs_d;
    fbd = reg_write_m && write_reg_m != 0 && write_reg_m == rt_d;
    lw  = mem_to_reg_e && (rt_e == rs_d || rt_e == rt_d);
    br  = branch_d && ((reg_write_e && write_reg_e != 0 && (write_reg_e == rs_d || write_reg_e == rt_d)) ||
                       (mem_to_reg_m && write_reg_m != 0 && (write_reg_m == rs_d || write_reg_m == rt_d)));
    hz  = lw || br;
    return {fwd_e(rs_e), fwd_e(rt_e), fad, fbd, hz || ms, hz || ms, ms, ms, hz && !ms, ms, me};
  endfunction

  function automatic logic model_stall(input int k);
    if (!rst_n) return 1'b0;
    if (merr[k]) return 1'b1;
    if (mlen[k] == 0) return mem_req_m && !mem_ready_m;
    return !mem_ready_m;
  endfunction

  task automatic model_step(input int k);
    logic s;
    s = model_stall(k);
    if (!rst_n) begin
      mlen[k] = 0; merr[k] = 1'b0;
    end else if (!merr[k]) begin
      if (s) begin
        mlen[k]++;
        if (mlen[k] == tmo[k]) merr[k] = 1'b1;
      end else begin
        mlen[k] = 0;
      end
    end
  endtask

  task automatic clear_inputs();
    {rs_d, rt_d, rs_e, rt_e} = '0;
    {write_reg_e, write_reg_m, write_reg_w} = '0;
    {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m} = '0;
    {branch_d, mem_req_m, mem_ready_m} = '0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    mlen = '{0, 0};
    merr = '{1'b0, 1'b0};

    // Reset: memory stall suppressed, load-use still visible combinationally.
    @(negedge clk);
    mem_req_m = 1'b1; mem_to_reg_e = 1'b1; rt_e = 5'd3; rs_d = 5'd3; rt_d = 5'd1;
    #1;
    check("rst_stall_e", 16'(se0), 16'd0);
    check("rst_mem_error", 16'(me1), 16'd0);
    check("rst_stall_f", 16'(sf0), 16'd1);
    check("rst_flush_e", 16'(fe0), 16'd1);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Forwarding priority and zero register.
    reg_write_m = 1'b1; write_reg_m = 5'd8; reg_write_w = 1'b1; write_reg_w = 5'd8; rs_e = 5'd8;
    #1 check("fwd_m_priority", 16'(fae0), 16'd2);
    write_reg_m = 5'd0;
    #1 check("fwd_w", 16'(fae0), 16'd1);
    clear_inputs();
    reg_write_m = 1'b1;
    #1 check("fwd_zero_e", 16'(fae0), 16'd0);
    check("fwd_zero_d", 16'(fad0), 16'd0);

    // Load-use interlock.
    clear_inputs();
    mem_to_reg_e = 1'b1; rt_e = 5'd5; rs_d = 5'd5; rt_d = 5'd9;
    #1 check("lu_stalls", 16'({sf0, sd0, fe0, se0}), 16'b1110);
    // Branch on an M-stage load result.
    clear_inputs();
    branch_d = 1'b1; mem_to_reg_m = 1'b1; write_reg_m = 5'd7; rt_d = 5'd7; rs_d = 5'd2; rt_e = 5'd4;
    #1 check("br_stall", 16'({sf0, fe0, se0}), 16'b110);

    // Memory wait of 3 cycles, with a load-use present so mem_stall must dominate.
    clear_inputs();
    @(negedge clk);
    mem_req_m = 1'b1; mem_to_reg_e = 1'b1; rt_e = 5'd6; rs_d = 5'd6; rt_d = 5'd1;
    for (int c = 0; c < 3; c++) begin
      #1 check("memwait_stall", 16'({se0, sm0, fw0, sf0, fe0}), 16'b11110);
      @(negedge clk);
    end
    mem_to_reg_e = 1'b0; mem_ready_m = 1'b1;
    #1 check("memwait_release", 16'({sf0, sd0, se0, sm0, fw0, fe0}), 16'd0);
    @(negedge clk);
    mem_req_m = 1'b0; mem_ready_m = 1'b0;
    #1 check("memwait_back_run", 16'({se0, se1}), 16'd0);

    // Timeout: dut4 errors after 4 stall cycles, default instance does not.
    @(negedge clk);
    mem_req_m = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 check("tmo_pre", 16'({se1, me1}), 16'b10);
      @(negedge clk);
    end
    #1 check("tmo_error", 16'({me1, se1, sf1, fw1}), 16'b1111);
    check("tmo_default_noerr", 16'({me0, se0}), 16'b01);
    mem_ready_m = 1'b1;
    #1 check("tmo_ready_ignored", 16'({me1, se1}), 16'b11);
    check("tmo_default_release", 16'(se0), 16'd0);
    @(negedge clk);
    #1 check("tmo_sticky", 16'({me1, se1}), 16'b11);
    #1 rst_n = 1'b0;
    #1 check("tmo_async_rst", 16'({me1, se1, sf1}), 16'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_req_m = 1'b0; mem_ready_m = 1'b0;
    #1 check("tmo_after_rst", 16'({me1, se1, sf1}), 16'd0);

`ifdef HAZARD_STATS_EN
    // Stall statistics: 5 load-use cycles, then drive to saturation.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    mem_to_reg_e = 1'b1; rt_e = 5'd5; rs_d = 5'd5;
    repeat (5) @(negedge clk);
    check("stats_five", sc0, 16'd5);
    repeat (65535) @(negedge clk);
    check("stats_saturate", sc0, 16'hFFFF);
    clear_inputs();
`endif

    // Randomized traffic against the model, with periodic reset pulses.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mlen = '{0, 0};
    merr = '{1'b0, 1'b0};
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst_n = (i % 60) != 59;
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      write_reg_e = 5'($urandom_range(0, 3));
      write_reg_m = 5'($urandom_range(0, 3));
      write_reg_w = 5'($urandom_range(0, 3));
      {reg_write_e, reg_write_m, reg_write_w} = 3'($urandom);
      {mem_to_reg_e, mem_to_reg_m, branch_d} = 3'($urandom);
      mem_req_m   = 1'($urandom_range(0, 1));
      mem_ready_m = ($urandom_range(0, 3) == 0);
      #1;
      check("rand_t16", 16'(obs0), 16'(expect_out(model_stall(0), rst_n && merr[0])));
      check("rand_t4",  16'(obs1), 16'(expect_out(model_stall(1), rst_n && merr[1])));
      model_step(0);
      model_step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
